bitwise_lu_pipe: RTL and testbench

- Parametrised, registered bitwise logic unit; successor to the team's fixed 4-bit combinational NOT/OR/NOR/AND/NAND/XOR/XNOR block.
- Adds:
  - runtime opcode select
  - WIDTH-bit operands
  - valid/ready handshake with one output register stage
  - accumulate mode: operand A comes from an internal accumulator, and the result is written back
  - result flags
  - completed-operation counter
- Sits between a register-file/sequencer front end and downstream datapath consumers.

---
 rtl/bitwise_pkg.sv | 22 ++
 rtl/bitwise_op_core.sv | 28 ++
 rtl/bitwise_lu_pipe.sv | 108 ++++++++++
 tb/tb_bitwise_lu_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared opcode encoding and helpers for the bitwise logic unit and its operation core.
package bitwise_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOT    = 3'd0;
    localparam op_t OP_OR     = 3'd1;
    localparam op_t OP_NOR    = 3'd2;
    localparam op_t OP_AND    = 3'd3;
    localparam op_t OP_NAND   = 3'd4;
    localparam op_t OP_XOR    = 3'd5;
    localparam op_t OP_XNOR   = 3'd6;
    localparam op_t OP_PASS_B = 3'd7;

    // Result flags travel with the result so consumers never recompute them.
    typedef struct packed {
        logic zero;
        logic ones;
        logic parity;
    } flags_t;

endpackage

// File: rtl/bitwise_op_core.sv
// Purely combinational, bit-parallel bitwise operation selected by a 3-bit opcode.
module bitwise_op_core
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] r_o
);

    always_comb begin
        r_o = b_i;
        case (op_i)
            OP_NOT:    r_o = ~a_i;
            OP_OR:     r_o = a_i | b_i;
            OP_NOR:    r_o = ~(a_i | b_i);
            OP_AND:    r_o = a_i & b_i;
            OP_NAND:   r_o = ~(a_i & b_i);
            OP_XOR:    r_o = a_i ^ b_i;
            OP_XNOR:   r_o = ~(a_i ^ b_i);
            OP_PASS_B: r_o = b_i;
            default:   r_o = b_i;
        endcase
    end

endmodule

// File: rtl/bitwise_lu_pipe.sv
// Registered bitwise logic unit: one output stage with valid/ready, accumulate mode,
// result flags and a count of accepted input transfers.
module bitwise_lu_pipe
    import bitwise_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [2:0]       op_in,
    input  logic             acc_mode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             acc_clr_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] y_out,
    output logic             zero_out,
    output logic             ones_out,
    output logic             parity_out,
    output logic [WIDTH-1:0] acc_out,
    output logic [CNT_W-1:0] op_count_out
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    flags_t           flags_q, flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             xfer;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    // Handshake: a transfer happens on any edge where valid and ready are both high on
    // that side; the output stage is free when empty or being drained this same cycle,
    // so a new result can replace a consumed one with no bubble.
    assign in_ready_out = !valid_q || out_ready_in;
    assign xfer         = in_valid_in && in_ready_out;

    // Accumulate mode reads the pre-update accumulator, so back-to-back chains see
    // the previous write-back.
    assign op_a = acc_mode_in ? acc_q : a_in;

    bitwise_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i  (op_a),
        .b_i  (b_in),
        .op_i (op_t'(op_in)),
        .r_o  (result)
    );

    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        flags_d = flags_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        if (xfer) begin
            valid_d        = 1'b1;
            y_d            = result;
            flags_d.zero   = (result == '0);
            flags_d.ones   = &result;
            flags_d.parity = ^result;
            cnt_d          = cnt_q + CNT_W'(1);
        end else if (valid_q && out_ready_in) begin
            valid_d = 1'b0;
        end

        // Clear beats the accumulate write-back; the transfer itself still completes.
        if (acc_clr_in) begin
            acc_d = '0;
        end else if (xfer && acc_mode_in) begin
            acc_d = result;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            flags_q <= '0;
            acc_q   <= ACC_INIT;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            flags_q <= flags_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid_out = valid_q;
    assign y_out         = y_q;
    assign zero_out      = flags_q.zero;
    assign ones_out      = flags_q.ones;
    assign parity_out    = flags_q.parity;
    assign acc_out       = acc_q;
    assign op_count_out  = cnt_q;

endmodule

// File: tb/tb_bitwise_lu_pipe.sv
// Bench for bitwise_lu_pipe (WIDTH=8, CNT_W=4): directed scenarios plus random traffic
// against a transaction-level reference model and an expected-result queue.
module tb_bitwise_lu_pipe;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic         acc_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero_f;
    logic         ones_f;
    logic         parity_f;
    logic [W-1:0] acc;
    logic [C-1:0] op_count;

    bitwise_lu_pipe #(
        .WIDTH    (W),
        .CNT_W    (C),
        .ACC_INIT (8'h00)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .op_in         (op),
        .acc_mode_in   (acc_mode),
        .a_in          (a),
        .b_in          (b),
        .acc_clr_in    (acc_clr),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .y_out         (y),
        .zero_out      (zero_f),
        .ones_out      (ones_f),
        .parity_out    (parity_f),
        .acc_out       (acc),
        .op_count_out  (op_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic         m_valid;
    logic [W-1:0] m_y;
    logic         m_zero, m_ones, m_par;
    logic [W-1:0] m_acc;
    int           m_cnt;

    function automatic logic [W-1:0] ref_op(int code, logic [W-1:0] x, logic [W-1:0] z);
        case (code)
            0:       return ~x;
            1:       return x | z;
            2:       return ~(x | z);
            3:       return x & z;
            4:       return ~(x & z);
            5:       return x ^ z;
            6:       return ~(x ^ z);
            default: return z;
        endcase
    endfunction

    function automatic logic odd_ones(logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return (n % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = '0;
        m_zero  = 1'b0;
        m_ones  = 1'b0;
        m_par   = 1'b0;
        m_acc   = 8'h00;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"},  32'(out_valid), 32'(m_valid));
        check({tag, "_y"},      32'(y),         32'(m_y));
        check({tag, "_zero"},   32'(zero_f),    32'(m_zero));
        check({tag, "_ones"},   32'(ones_f),    32'(m_ones));
        check({tag, "_parity"}, 32'(parity_f),  32'(m_par));
        check({tag, "_acc"},    32'(acc),       32'(m_acc));
        check({tag, "_cnt"},    32'(op_count),  32'(m_cnt));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int code, input logic mode,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic clr, input logic ordy);
        in_valid  = v;
        op        = 3'(code);
        acc_mode  = mode;
        a         = av;
        b         = bv;
        acc_clr   = clr;
        out_ready = ordy;
    endtask

    // One clock: pre-edge handshake checks, edge, model update, post-edge state checks.
    task automatic cycle(input string tag);
        logic         accept;
        logic [W-1:0] opa;
        logic [W-1:0] r;
        #1;
        check({tag, "_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check({tag, "_sb_extra"}, 32'(out_valid), 32'(0));
            else                   check({tag, "_sb_y"}, 32'(y), 32'(exp_q.pop_front()));
        end
        accept = in_valid && (!m_valid || out_ready);
        opa    = acc_mode ? m_acc : a;
        r      = ref_op(int'(op), opa, b);
        @(posedge clk);
        if (accept) begin
            m_y     = r;
            m_zero  = (r == 8'h00);
            m_ones  = (r == 8'hFF);
            m_par   = odd_ones(r);
            m_valid = 1'b1;
            m_cnt   = (m_cnt + 1) % (1 << C);
            exp_q.push_back(r);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (acc_clr)                 m_acc = 8'h00;
        else if (accept && acc_mode) m_acc = r;
        #1;
        check_state(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("reset");
        drive(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] s1_exp[8];

    initial begin
        s1_exp = '{8'h5A, 8'hBD, 8'h42, 8'h24, 8'hDB, 8'h99, 8'h66, 8'h3C};
        rst_n  = 1'b0;
        drive(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        #3;
        apply_reset();

        // Each opcode once on A5/3C.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1);
            cycle("s1");
            check("s1_table_y", 32'(y), 32'(s1_exp[i]));
            if (i == 5) check("s1_parity_99", 32'(parity_f), 32'(0));
        end
        drive(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        cycle("s1_drain");

        // Backpressure holds the result and blocks the pending op.
        apply_reset();
        drive(1'b1, 5, 1'b0, 8'hFF, 8'h0F, 1'b0, 1'b1);
        cycle("s2_acc");
        check("s2_y_first", 32'(y), 32'(8'hF0));
        drive(1'b1, 3, 1'b0, 8'h12, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("s2_hold");
            check("s2_hold_y", 32'(y), 32'(8'hF0));
            check("s2_hold_rdy", 32'(in_ready), 32'(0));
            check("s2_hold_cnt", 32'(op_count), 32'(1));
        end
        out_ready = 1'b1;
        cycle("s2_release");
        check("s2_new_y", 32'(y), 32'(8'h12));
        check("s2_new_cnt", 32'(op_count), 32'(2));

        // Accumulate chain, then NOT twice, then clear collision.
        apply_reset();
        drive(1'b1, 1, 1'b1, 8'hEE, 8'h01, 1'b0, 1'b1);
        cycle("s3");
        check("s3_acc1", 32'(acc), 32'(8'h01));
        b = 8'h02;
        cycle("s3");
        check("s3_acc2", 32'(acc), 32'(8'h03));
        b = 8'h80;
        cycle("s3");
        check("s3_acc3", 32'(acc), 32'(8'h83));
        check("s3_y3", 32'(y), 32'(8'h83));
        check("s3_ones", 32'(ones_f), 32'(0));
        op = 3'd0;
        cycle("s3_not");
        check("s3_not_y", 32'(y), 32'(8'h7C));
        cycle("s3_not2");
        check("s3_not2_acc", 32'(acc), 32'(8'h83));
        drive(1'b1, 3, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1);
        cycle("s4");
        check("s4_y", 32'(y), 32'(8'h83));
        check("s4_acc", 32'(acc), 32'(8'h00));

        // Counter wrap over 17 back-to-back transfers.
        apply_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, $urandom_range(0, 7), 1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
            cycle("s5");
            check("s5_cnt", 32'(op_count), 32'(i % 16));
            check("s5_valid", 32'(out_valid), 32'(1));
        end

        // Asynchronous reset between edges with a pending result.
        drive(1'b1, 7, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1);
        cycle("s6_load");
        drive(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cycle("s6_hold");
        check("s6_acc_pre", 32'(acc), 32'(8'h55));
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_valid", 32'(out_valid), 32'(0));
        check("s6_y", 32'(y), 32'(0));
        check("s6_acc", 32'(acc), 32'(8'h00));
        check("s6_cnt", 32'(op_count), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0);
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
